// File: rtl/remote_channel_driver.sv
// Drives the remote's four stick channels as 8-bit levels and PWM pins: arming passthrough, then slewed gesture tracking with failsafe.
// Latency: levels are registered (1 clk from initial_signal in ARMING); pwm_out is registered 1 clk after the count/duty compare.
// Backpressure: none; cmd_valid and arm_done are single-cycle strobes that are always accepted when meaningful.
module remote_channel_driver #(
    parameter int unsigned PWM_DIV   = 200,
    parameter int unsigned SLEW_STEP = 4,
    parameter int unsigned TIMEOUT   = 1 << 22,
    parameter logic [7:0]  CENTER    = 8'd128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] initial_signal,
    input  logic       arm_done,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_throttle,
    input  logic [7:0] cmd_yaw,
    input  logic [7:0] cmd_pitch,
    input  logic [7:0] cmd_roll,
    output logic [7:0] lvl_throttle,
    output logic [7:0] lvl_yaw,
    output logic [7:0] lvl_pitch,
    output logic [7:0] lvl_roll,
    output logic [3:0] pwm_out,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        ARMING   = 2'd0,
        RUN      = 2'd1,
        FAILSAFE = 2'd2
    } state_t;

    // Channel bundle, index 0 = throttle, 1 = yaw, 2 = pitch, 3 = roll (matches pwm_out bit order).
    typedef logic [3:0][7:0] chan_t;

    localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [8:0]       STEP9    = 9'(SLEW_STEP);
    // Safe resting position: throttle off, sticks centred.
    localparam chan_t            REST     = {CENTER, CENTER, CENTER, 8'd0};

    state_t           state_q;
    state_t           state_d;
    chan_t            lvl_q;
    chan_t            tgt_q;
    chan_t            duty_q;
    chan_t            cmd;
    logic [PRE_W-1:0] pre_q;
    logic [7:0]       cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic [3:0]       pwm_q;
    logic             tick;
    logic             boundary;
    logic             tmo_hit;

    assign cmd      = {cmd_roll, cmd_pitch, cmd_yaw, cmd_throttle};
    assign tick     = (pre_q == PRE_LAST);
    assign boundary = tick && (cnt_q == 8'hFF);
    assign tmo_hit  = (tmo_q == TMO_LAST);

    // Move one level toward its target by at most SLEW_STEP, never past the target and never outside 0..255.
    function automatic logic [7:0] slew_toward(input logic [7:0] lvl, input logic [7:0] tgt);
        logic [8:0] l9;
        logic [8:0] t9;
        logic [8:0] diff;
        logic [8:0] res;
        l9   = {1'b0, lvl};
        t9   = {1'b0, tgt};
        diff = '0;
        res  = l9;
        if (t9 > l9) begin
            diff = t9 - l9;
            res  = l9 + ((diff > STEP9) ? STEP9 : diff);
        end else if (l9 > t9) begin
            diff = l9 - t9;
            res  = l9 - ((diff > STEP9) ? STEP9 : diff);
        end
        if (res > 9'd255) begin
            res = 9'd255;
        end
        return res[7:0];
    endfunction

    // Mode register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARMING;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode transitions: a command arriving on the timeout cycle keeps the block in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARMING:   if (arm_done) state_d = RUN;
            RUN:      if (!cmd_valid && tmo_hit) state_d = FAILSAFE;
            FAILSAFE: if (cmd_valid) state_d = RUN;
            default:  state_d = ARMING;
        endcase
    end

    // PWM timebase: prescaler, 8-bit count and registered duty compare.
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= 8'd0;
            pwm_q <= 4'b0000;
        end else begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
            if (tick) begin
                cnt_q <= cnt_q + 8'd1;
            end
            for (int i = 0; i < 4; i++) begin
                pwm_q[i] <= (cnt_q < duty_q[i]);
            end
        end
    end

    // Duty capture: whole-period sampling, except throttle follows the arming level on every tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            duty_q <= REST;
        end else begin
            if (boundary) begin
                duty_q <= lvl_q;
            end
            if (state_q == ARMING && tick) begin
                duty_q[0] <= lvl_q[0];
            end
        end
    end

    // Levels, targets and command timeout.
    always_ff @(posedge clock) begin
        if (reset) begin
            lvl_q <= REST;
            tgt_q <= REST;
            tmo_q <= '0;
        end else begin
            case (state_q)
                ARMING: begin
                    tgt_q <= REST;
                    tmo_q <= '0;
                    if (arm_done) begin
                        lvl_q <= REST;
                    end else begin
                        lvl_q <= {CENTER, CENTER, CENTER, initial_signal};
                    end
                end
                RUN: begin
                    if (boundary) begin
                        for (int i = 0; i < 4; i++) begin
                            lvl_q[i] <= slew_toward(lvl_q[i], tgt_q[i]);
                        end
                    end
                    if (cmd_valid) begin
                        tgt_q <= cmd;
                        tmo_q <= '0;
                    end else if (tmo_hit) begin
                        tgt_q <= REST;
                        tmo_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                FAILSAFE: begin
                    tmo_q <= '0;
                    if (boundary) begin
                        for (int i = 0; i < 4; i++) begin
                            lvl_q[i] <= slew_toward(lvl_q[i], tgt_q[i]);
                        end
                    end
                    if (cmd_valid) begin
                        tgt_q <= cmd;
                    end
                end
                default: begin
                    lvl_q <= REST;
                    tgt_q <= REST;
                    tmo_q <= '0;
                end
            endcase
        end
    end

    assign lvl_throttle = lvl_q[0];
    assign lvl_yaw      = lvl_q[1];
    assign lvl_pitch    = lvl_q[2];
    assign lvl_roll     = lvl_q[3];
    assign pwm_out      = pwm_q;
    assign mode         = state_q;

endmodule

// File: tb/tb_remote_channel_driver.sv
// Scoreboard bench for remote_channel_driver with a fast PWM timebase and a short timeout.
// Stimulus pushes expectations tagged with the cycle they apply to; the monitor checks them on the falling edge.
// Runs to completion on its own; a global time limit guards against a stalled run.
module tb_remote_channel_driver;

    localparam int TMO = 10000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] initial_signal = 8'd0;
    logic       arm_done = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_throttle = 8'd0;
    logic [7:0] cmd_yaw = 8'd128;
    logic [7:0] cmd_pitch = 8'd128;
    logic [7:0] cmd_roll = 8'd128;
    logic [7:0] lvl_throttle;
    logic [7:0] lvl_yaw;
    logic [7:0] lvl_pitch;
    logic [7:0] lvl_roll;
    logic [3:0] pwm_out;
    logic [1:0] mode;

    always #5 clock = ~clock;

    remote_channel_driver #(
        .PWM_DIV   (1),
        .SLEW_STEP (4),
        .TIMEOUT   (TMO),
        .CENTER    (8'd128)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .initial_signal (initial_signal),
        .arm_done       (arm_done),
        .cmd_valid      (cmd_valid),
        .cmd_throttle   (cmd_throttle),
        .cmd_yaw        (cmd_yaw),
        .cmd_pitch      (cmd_pitch),
        .cmd_roll       (cmd_roll),
        .lvl_throttle   (lvl_throttle),
        .lvl_yaw        (lvl_yaw),
        .lvl_pitch      (lvl_pitch),
        .lvl_roll       (lvl_roll),
        .pwm_out        (pwm_out),
        .mode           (mode)
    );

    typedef enum int {K_THR, K_YAW, K_PITCH, K_ROLL, K_MODE, K_PWM, K_HI0, K_HI1} kind_t;
    typedef struct {
        int    due;
        kind_t kind;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int   ncyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   hi0 = 0;
    int   hi1 = 0;
    int   hidx = 0;
    bit   hist0 [256];
    bit   hist1 [256];

    function automatic int observe(kind_t k);
        case (k)
            K_THR:   return int'(lvl_throttle);
            K_YAW:   return int'(lvl_yaw);
            K_PITCH: return int'(lvl_pitch);
            K_ROLL:  return int'(lvl_roll);
            K_MODE:  return int'(mode);
            K_PWM:   return int'(pwm_out);
            K_HI0:   return hi0;
            K_HI1:   return hi1;
            default: return -1;
        endcase
    endfunction

    // Monitor: keep a 256-cycle high count of pwm_out[1:0] and retire every expectation due this cycle.
    always @(negedge clock) begin : monitor
        int i;
        ncyc++;
        hi0 = hi0 - int'(hist0[hidx]) + int'(pwm_out[0]);
        hi1 = hi1 - int'(hist1[hidx]) + int'(pwm_out[1]);
        hist0[hidx] = pwm_out[0];
        hist1[hidx] = pwm_out[1];
        hidx = (hidx + 1) % 256;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == ncyc) begin
                vectors++;
                if (observe(sb[i].kind) != sb[i].exp) begin
                    miscompares++;
                    $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                             sb[i].name, observe(sb[i].kind), sb[i].exp, ncyc);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    // Expectation for the outputs seen after dly further rising edges (dly=0: the edge about to come has no effect yet).
    task automatic expect_v(input kind_t k, input int v, input int dly, input string nm);
        sb.push_back('{ncyc + 1 + dly, k, v, nm});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_levels(input int t, input int y, input int p, input int r, input int dly, input string nm);
        expect_v(K_THR,   t, dly, {nm, "_thr"});
        expect_v(K_YAW,   y, dly, {nm, "_yaw"});
        expect_v(K_PITCH, p, dly, {nm, "_pitch"});
        expect_v(K_ROLL,  r, dly, {nm, "_roll"});
    endtask

    task automatic send_cmd(input int t, input int y, input int p, input int r);
        cmd_throttle = 8'(t);
        cmd_yaw      = 8'(y);
        cmd_pitch    = 8'(p);
        cmd_roll     = 8'(r);
        cmd_valid    = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int w;
        int v;
        step(3);
        // Reset state.
        expect_levels(0, 128, 128, 128, 0, "reset");
        expect_v(K_MODE, 0, 0, "reset_mode");
        expect_v(K_PWM,  0, 0, "reset_pwm");
        reset = 1'b0;
        step(1);

        // Arming passthrough: 16 x 0, 16 x 255, then 0 and a few other levels, 1 clock latency.
        for (int i = 0; i < 36; i++) begin
            if (i < 16)       v = 0;
            else if (i < 32)  v = 255;
            else if (i == 32) v = 0;
            else if (i == 33) v = 1;
            else if (i == 34) v = 254;
            else              v = 77;
            initial_signal = 8'(v);
            expect_v(K_THR, v, 1, "arm_pass_thr");
            if (i % 8 == 0) begin
                expect_v(K_YAW,  128, 1, "arm_yaw");
                expect_v(K_ROLL, 128, 1, "arm_roll");
                expect_v(K_MODE, 0,   1, "arm_mode");
            end
            step(1);
        end
        // cmd_valid is ignored while arming.
        send_cmd(10, 10, 10, 10);
        step(1);
        cmd_valid = 1'b0;
        expect_levels(77, 128, 128, 128, 0, "arm_cmd_ignored");
        expect_v(K_MODE, 0, 0, "arm_cmd_mode");

        // PWM duty in ARMING (1-clock PWM tick): throttle high count equals the level, yaw at centre.
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? 64 : (i == 1) ? 255 : 0;
            initial_signal = 8'(v);
            step(600);
            expect_v(K_HI0, v,   0, "pwm_thr_high_count");
            expect_v(K_HI1, 128, 0, "pwm_yaw_high_count");
        end

        // Arm: RUN next cycle, throttle forced to 0 despite a non-zero arming level.
        initial_signal = 8'd77;
        step(2);
        arm_done = 1'b1;
        expect_v(K_MODE, 0, 0, "arm_pre_mode");
        expect_v(K_MODE, 1, 1, "arm_done_mode");
        expect_v(K_THR,  0, 1, "arm_done_thr");
        step(1);
        arm_done = 1'b0;
        step(2);

        // Gesture command: slew +4 per boundary; yaw stops at 140 after 3, pitch down to 120 after 2.
        send_cmd(100, 140, 120, 128);
        step(1);
        cmd_valid = 1'b0;
        w = 0;
        while (lvl_throttle == 8'd0 && w < 300) begin
            @(negedge clock);
            w++;
        end
        vectors++;
        if (w >= 300) begin
            miscompares++;
            $display("FAIL slew_start: throttle still %0d after %0d cycles, expected a move within 256", lvl_throttle, w);
        end
        @(posedge clock);
        #1;
        expect_levels(4, 132, 124, 128, 0, "slew_b1");
        step(256);
        expect_levels(8, 136, 120, 128, 0, "slew_b2");
        step(256);
        expect_levels(12, 140, 120, 128, 0, "slew_b3");
        step(256);
        expect_levels(16, 140, 120, 128, 0, "slew_b4");
        step(21 * 256);
        expect_v(K_THR, 100, 0, "slew_b25_thr");
        step(256);
        expect_v(K_THR, 100, 0, "slew_no_overshoot");
        // arm_done has no effect once running.
        arm_done = 1'b1;
        expect_v(K_MODE, 1, 1, "run_arm_ignored");
        step(1);
        arm_done = 1'b0;
        step(257);
        expect_v(K_HI0, 100, 0, "pwm_run_thr_count");
        expect_v(K_HI1, 140, 0, "pwm_run_yaw_count");

        // Timeout: no command for TMO clocks -> FAILSAFE, then ramp to rest.
        send_cmd(100, 140, 120, 128);
        expect_v(K_MODE, 1, TMO,     "timeout_edge_minus1");
        expect_v(K_MODE, 2, TMO + 1, "timeout_failsafe");
        step(1);
        cmd_valid = 1'b0;
        step(TMO + 4);
        step(27 * 256);
        expect_levels(0, 128, 128, 128, 0, "failsafe_rest");
        expect_v(K_MODE, 2, 0, "failsafe_mode");
        arm_done = 1'b1;
        expect_v(K_MODE, 2, 1, "failsafe_arm_ignored");
        step(1);
        arm_done = 1'b0;
        step(1);
        send_cmd(50, 128, 128, 128);
        expect_v(K_MODE, 2, 0, "failsafe_exit_pre");
        expect_v(K_MODE, 1, 1, "failsafe_exit_run");
        step(1);
        cmd_valid = 1'b0;

        // Command on the exact timeout cycle wins.
        step(TMO - 1);
        send_cmd(60, 136, 128, 124);
        expect_v(K_MODE, 1, 1, "tmo_race_mode1");
        expect_v(K_MODE, 1, 2, "tmo_race_mode2");
        expect_v(K_MODE, 1, 3, "tmo_race_mode3");
        step(1);
        cmd_valid = 1'b0;
        step(5 * 256);
        expect_levels(60, 136, 128, 124, 0, "tmo_race_targets");
        expect_v(K_MODE, 1, 0, "tmo_race_mode_late");

        // Reset mid-RUN with throttle at 200.
        send_cmd(200, 136, 128, 124);
        step(1);
        cmd_valid = 1'b0;
        step(37 * 256);
        expect_v(K_THR,  200, 0, "pre_reset_thr");
        expect_v(K_MODE, 1,   0, "pre_reset_mode");
        reset = 1'b1;
        expect_levels(0, 128, 128, 128, 1, "mid_reset");
        expect_v(K_MODE, 0, 1, "mid_reset_mode");
        expect_v(K_PWM,  0, 1, "mid_reset_pwm");
        step(1);
        reset = 1'b0;
        step(4);

        while (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: never checked (due cycle %0d, now %0d)", sb[0].name, sb[0].due, ncyc);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
